// File: rtl/projectfile_seg_display_ctrl.sv
// Six-digit seven-segment display controller, Avalon-MM slave.
// Glyph decode, decimal points, display enable and hardware blink timer.
module projectfile_seg_display_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5
);

  logic        wr;
  logic [23:0] digits_q, digits_d;
  logic        en_q, en_d;
  logic [5:0]  blink_q, blink_d;
  logic [5:0]  dp_q, dp_d;
  logic [23:0] div_q, div_d;
  logic [23:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        tmr_clr;
  logic [7:0]  seg_q [6];
  logic [7:0]  seg_d [6];
  logic        unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata[31:24];

  function automatic logic [6:0] dec(input logic [3:0] c);
    logic [6:0] r;
    case (c)
      4'h0:    r = 7'h40;
      4'h1:    r = 7'h79;
      4'h2:    r = 7'h24;
      4'h3:    r = 7'h30;
      4'h4:    r = 7'h19;
      4'h5:    r = 7'h12;
      4'h6:    r = 7'h02;
      4'h7:    r = 7'h78;
      4'h8:    r = 7'h00;
      4'h9:    r = 7'h10;
      4'hA:    r = 7'h08;
      4'hB:    r = 7'h03;
      4'hC:    r = 7'h46;
      4'hD:    r = 7'h21;
      4'hE:    r = 7'h06;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  always_comb begin
    digits_d = digits_q;
    en_d     = en_q;
    blink_d  = blink_q;
    dp_d     = dp_q;
    div_d    = div_q;
    if (wr) begin
      unique case (address)
        2'd0: digits_d = writedata[23:0];
        2'd1: begin
          en_d    = writedata[0];
          blink_d = writedata[13:8];
          dp_d    = writedata[21:16];
        end
        2'd2: div_d = writedata[23:0];
        default: ;
      endcase
    end
  end

  // A restart request beats a coincident terminal count.
  assign tmr_clr = wr & ((address == 2'd2) |
                         ((address == 2'd3) & writedata[0]));

  always_comb begin
    cnt_d   = cnt_q + 24'd1;
    phase_d = phase_q;
    if (tmr_clr || div_q == 24'd0) begin
      cnt_d   = 24'd0;
      phase_d = 1'b1;
    end else if (cnt_q == div_q - 24'd1) begin
      cnt_d   = 24'd0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      seg_d[i] = (en_q & (~blink_q[i] | phase_q)) ?
                 {~dp_q[i], dec(digits_q[4*i +: 4])} : 8'hFF;
    end
  end

  always_comb begin
    readdata = 32'd0;
    unique case (address)
      2'd0: readdata = {8'd0, digits_q};
      2'd1: readdata = {10'd0, dp_q, 2'd0, blink_q, 7'd0, en_q};
      2'd2: readdata = {8'd0, div_q};
      2'd3: readdata = {31'd0, phase_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= 24'hFFFFFF;
      en_q     <= 1'b0;
      blink_q  <= 6'd0;
      dp_q     <= 6'd0;
      div_q    <= 24'd0;
      cnt_q    <= 24'd0;
      phase_q  <= 1'b1;
      for (int i = 0; i < 6; i++) seg_q[i] <= 8'hFF;
    end else begin
      digits_q <= digits_d;
      en_q     <= en_d;
      blink_q  <= blink_d;
      dp_q     <= dp_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      for (int i = 0; i < 6; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];

endmodule

// File: tb/tb_projectfile_seg_display_ctrl.sv
// Directed self-checking bench for projectfile_seg_display_ctrl.
// Inputs change on the falling edge; outputs are checked there too.
module tb_projectfile_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5;
  logic [7:0]  sg [6];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  projectfile_seg_display_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg3(seg3), .seg4(seg4), .seg5(seg5)
  );

  assign sg[0] = seg0;
  assign sg[1] = seg1;
  assign sg[2] = seg2;
  assign sg[3] = seg3;
  assign sg[4] = seg4;
  assign sg[5] = seg5;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'h00FFFFFF, 32'h0, 32'h0, 32'h1};
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== 8'hFF) begin
        fails++;
        $display("FAIL reset_seg%0d got %h exp ff", i, sg[i]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      tests++;
      if (readdata !== exp_rd[a]) begin
        fails++;
        $display("FAIL reset_read%0d got %h exp %h", a, readdata, exp_rd[a]);
      end
    end
    @(negedge clk);
    wr(2'd0, 32'h00123456);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== 8'hFF) begin
        fails++;
        $display("FAIL en_off_seg%0d got %h exp ff", i, sg[i]);
      end
    end
  endtask

  task automatic test_readback();
    wr(2'd1, 32'hFFFFFFFF);
    tests++;
    if (readdata !== 32'h003F3F01) begin
      fails++;
      $display("FAIL rb_ctrl got %h exp 003f3f01", readdata);
    end
    wr(2'd0, 32'hAB123456);
    tests++;
    if (readdata !== 32'h00123456) begin
      fails++;
      $display("FAIL rb_digits got %h exp 00123456", readdata);
    end
    wr(2'd2, 32'hFF000005);
    tests++;
    if (readdata !== 32'h00000005) begin
      fails++;
      $display("FAIL rb_div got %h exp 00000005", readdata);
    end
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h0);
    address = 2'd3;
    #1;
    tests++;
    if (readdata !== 32'h1) begin
      fails++;
      $display("FAIL rb_status got %h exp 1", readdata);
    end
  endtask

  task automatic test_decode();
    logic [31:0] pat [3];
    logic [7:0]  ex [3][6];
    pat = '{32'h00123456, 32'h00ABCDE0, 32'h00789000};
    ex[0] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    ex[1] = '{8'hC0, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
    ex[2] = '{8'hC0, 8'hC0, 8'hC0, 8'h90, 8'h80, 8'hF8};
    @(negedge clk);
    wr(2'd1, 32'h1);
    for (int p = 0; p < 3; p++) begin
      wr(2'd0, pat[p]);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (sg[i] !== ex[p][i]) begin
          fails++;
          $display("FAIL decode%0d_seg%0d got %h exp %h",
                   p, i, sg[i], ex[p][i]);
        end
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] e0 [6];
    logic [7:0] e1 [6];
    e0 = '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0};
    e1 = '{8'hFF, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hFF};
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h00140001);
    tests++;
    if (readdata !== 32'h00140001) begin
      fails++;
      $display("FAIL dp_ctrl_read got %h exp 00140001", readdata);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== e0[i]) begin
        fails++;
        $display("FAIL dp_seg%0d got %h exp %h", i, sg[i], e0[i]);
      end
    end
    wr(2'd0, 32'h00F0000F);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== e1[i]) begin
        fails++;
        $display("FAIL blank_seg%0d got %h exp %h", i, sg[i], e1[i]);
      end
    end
  endtask

  task automatic test_blink();
    logic       ph;
    logic [7:0] es;
    wr(2'd0, 32'h0);
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h00000301);
    address = 2'd3;
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      ph = ((k / 4) % 2) == 0;
      es = (((k - 1) / 4) % 2 == 0) ? 8'hC0 : 8'hFF;
      tests++;
      if (readdata !== {31'd0, ph}) begin
        fails++;
        $display("FAIL blink_phase k%0d got %h exp %h", k, readdata, ph);
      end
      tests++;
      if (seg0 !== es || seg1 !== es) begin
        fails++;
        $display("FAIL blink_seg01 k%0d got %h/%h exp %h",
                 k, seg0, seg1, es);
      end
      tests++;
      if ({seg2, seg3, seg4, seg5} !== {4{8'hC0}}) begin
        fails++;
        $display("FAIL steady_seg2to5 k%0d got %h exp c0c0c0c0",
                 k, {seg2, seg3, seg4, seg5});
      end
    end
  endtask

  task automatic test_status_clear();
    logic ex [6];
    int   gap [6];
    gap = '{2, 0, 3, 1, 7, 0};
    ex  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int s = 0; s < 6; s++) begin
      repeat (gap[s]) @(negedge clk);
      if (s == 1 || s == 5) wr(2'd3, 32'h1);
      tests++;
      if (readdata[0] !== ex[s]) begin
        fails++;
        $display("FAIL status_clr%0d got %b exp %b", s, readdata[0], ex[s]);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (readdata[0] !== 1'b1) begin
      fails++;
      $display("FAIL status_after3 got %b exp 1", readdata[0]);
    end
    @(negedge clk);
    tests++;
    if (readdata[0] !== 1'b0) begin
      fails++;
      $display("FAIL status_after4 got %b exp 0", readdata[0]);
    end
  endtask

  task automatic test_div_edge();
    wr(2'd2, 32'd1);
    address = 2'd3;
    #1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) @(negedge clk);
      tests++;
      if (readdata[0] !== (i % 2 == 0)) begin
        fails++;
        $display("FAIL div1_phase%0d got %b exp %b",
                 i, readdata[0], (i % 2 == 0));
      end
    end
    wr(2'd2, 32'd0);
    address = 2'd3;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (seg0 !== 8'hC0 || seg1 !== 8'hC0 || readdata[0] !== 1'b1) begin
        fails++;
        $display("FAIL div0_steady%0d got %h/%h ph %b exp c0/c0 ph 1",
                 i, seg0, seg1, readdata[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e [6];
    e = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    wr(2'd2, 32'd4);
    address = 2'd3;
    repeat (5) @(negedge clk);
    tests++;
    if (readdata[0] !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_phase got %b exp 0", readdata[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (readdata[0] !== 1'b1) begin
      fails++;
      $display("FAIL arst_phase got %b exp 1", readdata[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== 8'hFF) begin
        fails++;
        $display("FAIL arst_seg%0d got %h exp ff", i, sg[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({seg0, seg1, seg2, seg3, seg4, seg5} !== {6{8'hFF}}) begin
      fails++;
      $display("FAIL post_reset_blank got %h exp all ff",
               {seg0, seg1, seg2, seg3, seg4, seg5});
    end
    wr(2'd1, 32'h1);
    @(negedge clk);
    tests++;
    if (seg0 !== 8'hFF) begin
      fails++;
      $display("FAIL post_reset_digits_blank got %h exp ff", seg0);
    end
    wr(2'd0, 32'h00654321);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sg[i] !== e[i]) begin
        fails++;
        $display("FAIL rewrite_seg%0d got %h exp %h", i, sg[i], e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_decode();
    test_dp();
    test_blink();
    test_status_clear();
    test_div_edge();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
